// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ------------------------------------------------------------------
// multicycle_control_fsm : RV32I multicycle main control unit
// Rev 1.0
// ------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int STATE_W  = 4,
  parameter int WAIT_W   = 8,
  parameter int MAX_WAIT = 200,
  parameter int COUNT_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write_cond,
  output logic               pc_write,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic [1:0]         mem_to_reg,
  output logic               reg_write,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic [STATE_W-1:0] state,
  output logic               is_halted,
  output logic               bus_error,
  output logic [COUNT_W-1:0] cycle_count,
  output logic [COUNT_W-1:0] instr_count
);

  typedef enum logic [STATE_W-1:0] {
    S_IF   = STATE_W'(0),
    S_ID   = STATE_W'(1),
    S_MA   = STATE_W'(2),
    S_MR   = STATE_W'(3),
    S_LWB  = STATE_W'(4),
    S_MW   = STATE_W'(5),
    S_EXR  = STATE_W'(6),
    S_EXI  = STATE_W'(7),
    S_AWB  = STATE_W'(8),
    S_BR   = STATE_W'(9),
    S_JAL  = STATE_W'(10),
    S_JALR = STATE_W'(11),
    S_HALT = STATE_W'(12)
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // The timeout fires on the stall cycle that brings the count up to MAX_WAIT.
  localparam logic [WAIT_W-1:0] TIMEOUT_AT = WAIT_W'(MAX_WAIT - 1);

  state_t             cur;
  state_t             nxt;
  state_t             succ;
  logic [WAIT_W-1:0]  stall_cnt;
  logic               in_stall;
  logic               timeout;

  function automatic state_t rom1(input logic [6:0] op);
    case (op)
      OP_R:      rom1 = S_EXR;
      OP_I:      rom1 = S_EXI;
      OP_LOAD:   rom1 = S_MA;
      OP_STORE:  rom1 = S_MA;
      OP_BRANCH: rom1 = S_BR;
      OP_JAL:    rom1 = S_JAL;
      OP_JALR:   rom1 = S_JALR;
      OP_SYSTEM: rom1 = S_HALT;
      default:   rom1 = S_IF;
    endcase
  endfunction

  function automatic state_t rom2(input logic [6:0] op);
    case (op)
      OP_LOAD:  rom2 = S_MR;
      OP_STORE: rom2 = S_MW;
      default:  rom2 = S_IF;
    endcase
  endfunction

  assign succ      = state_t'(cur + STATE_W'(1));
  assign in_stall  = (cur == S_IF) || (cur == S_MR) || (cur == S_MW);
  assign timeout   = (MAX_WAIT != 0) && in_stall && !mem_ready && (stall_cnt == TIMEOUT_AT);
  assign state     = cur;
  assign is_halted = (cur == S_HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= S_IF;
    else       cur <= nxt;
  end

  always_comb begin
    nxt           = cur;
    pc_write_cond = 1'b0;
    pc_write      = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 2'b00;
    reg_write     = 1'b0;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    case (cur)
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready)    nxt = succ;
        else if (timeout) nxt = S_HALT;
      end
      S_ID: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        nxt       = rom1(opcode);
      end
      S_MA: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        nxt       = rom2(opcode);
      end
      S_MR: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready)    nxt = succ;
        else if (timeout) nxt = S_HALT;
      end
      S_LWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        nxt        = S_IF;
      end
      S_MW: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready)    nxt = S_IF;
        else if (timeout) nxt = S_HALT;
      end
      S_EXR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        nxt       = S_AWB;
      end
      S_EXI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
        alu_op    = 2'b10;
        nxt       = succ;
      end
      S_AWB: begin
        reg_write = 1'b1;
        nxt       = S_IF;
      end
      S_BR: begin
        alu_src_a     = 2'b10;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        nxt           = S_IF;
      end
      S_JAL: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b10;
        pc_write   = 1'b1;
        pc_source  = 2'b01;
        nxt        = S_IF;
      end
      S_JALR: begin
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b10;
        reg_write  = 1'b1;
        mem_to_reg = 2'b10;
        pc_write   = 1'b1;
        nxt        = S_IF;
      end
      S_HALT:  nxt = S_HALT;
      default: nxt = S_IF;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt   <= '0;
      bus_error   <= 1'b0;
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (nxt != cur)
        stall_cnt <= '0;
      else if (in_stall && !mem_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + WAIT_W'(1);
      if (timeout)
        bus_error <= 1'b1;
      if (cur != S_HALT)
        cycle_count <= cycle_count + COUNT_W'(1);
      if ((nxt == S_IF) && (cur != S_IF))
        instr_count <= instr_count + COUNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_fsm.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_multicycle_control_fsm : vector table + scoreboard bench
// Rev 1.0
// ------------------------------------------------------------------
module tb_multicycle_control_fsm;

  localparam logic [3:0] T_IF = 4'd0, T_ID = 4'd1, T_MA = 4'd2, T_MR = 4'd3,
                         T_LWB = 4'd4, T_MW = 4'd5, T_EXR = 4'd6, T_EXI = 4'd7,
                         T_AWB = 4'd8, T_BR = 4'd9, T_JAL = 4'd10, T_JALR = 4'd11,
                         T_HALT = 4'd12;
  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, L = 7'b0000011,
                         S = 7'b0100011, B = 7'b1100011, J = 7'b1101111,
                         JR = 7'b1100111, E = 7'b1110011, NOP = 7'b0000000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  opcode = '0;
  logic        mem_ready = 1'b0;
  logic        pc_write_cond, pc_write, iord, mem_read, mem_write, ir_write, reg_write;
  logic [1:0]  mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source;
  logic [3:0]  state;
  logic        is_halted, bus_error;
  logic [31:0] cycle_count, instr_count;
  logic [16:0] ctrl;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.STATE_W(4), .WAIT_W(8), .MAX_WAIT(5), .COUNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write_cond(pc_write_cond), .pc_write(pc_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .state(state), .is_halted(is_halted), .bus_error(bus_error),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  assign ctrl = {pc_write_cond, pc_write, iord, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_source};

  typedef struct { logic [6:0] op; logic mr; logic [3:0] st; } vec_t;
  typedef struct { logic [3:0] st; logic [16:0] ctrl; logic [31:0] cyc;
                   logic [31:0] ins; logic halt; logic berr; } exp_t;

  vec_t        tbl[$];
  exp_t        sb[$];
  exp_t        mon_e;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [3:0]  prev_st = T_IF;
  logic [31:0] ecyc = 0;
  logic [31:0] eins = 0;
  logic        ebus = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected control word per state, written straight from the output table.
  function automatic logic [16:0] exp_ctrl(input logic [3:0] st, input logic mr);
    logic pwc, pw, io, mrd, mwr, irw, rw;
    logic [1:0] mtr, a, b, op, ps;
    {pwc, pw, io, mrd, mwr, irw, rw} = '0;
    {mtr, a, b, op, ps} = '0;
    case (st)
      T_IF:   begin mrd = 1; b = 2'b01; irw = mr; pw = mr; end
      T_ID:   begin a = 2'b01; b = 2'b10; end
      T_MA:   begin a = 2'b10; b = 2'b10; end
      T_MR:   begin mrd = 1; io = 1; end
      T_LWB:  begin rw = 1; mtr = 2'b01; end
      T_MW:   begin mwr = 1; io = 1; end
      T_EXR:  begin a = 2'b10; op = 2'b10; end
      T_EXI:  begin a = 2'b10; b = 2'b10; op = 2'b10; end
      T_AWB:  begin rw = 1; end
      T_BR:   begin a = 2'b10; op = 2'b01; pwc = 1; ps = 2'b01; end
      T_JAL:  begin rw = 1; mtr = 2'b10; pw = 1; ps = 2'b01; end
      T_JALR: begin a = 2'b10; b = 2'b10; rw = 1; mtr = 2'b10; pw = 1; end
      default: ;
    endcase
    return {pwc, pw, io, mrd, mwr, irw, mtr, rw, a, b, op, ps};
  endfunction

  always @(negedge clk) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      chk("state", 32'(state), 32'(mon_e.st));
      chk("ctrl", 32'(ctrl), 32'(mon_e.ctrl));
      chk("cycle_count", cycle_count, mon_e.cyc);
      chk("instr_count", instr_count, mon_e.ins);
      chk("is_halted", 32'(is_halted), 32'(mon_e.halt));
      chk("bus_error", 32'(bus_error), 32'(mon_e.berr));
    end
  end

  // One clock: drive inputs after the edge and queue what the DUT must show this cycle.
  task automatic cyc(input logic [6:0] op, input logic mr, input logic [3:0] st);
    exp_t e;
    @(posedge clk); #1;
    if (prev_st != T_HALT) ecyc++;
    if (st == T_IF && prev_st != T_IF) eins++;
    prev_st   = st;
    opcode    = op;
    mem_ready = mr;
    e.st = st; e.ctrl = exp_ctrl(st, mr); e.cyc = ecyc; e.ins = eins;
    e.halt = (st == T_HALT); e.berr = ebus;
    sb.push_back(e);
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    #1;
    reset = 1'b1;
    mem_ready = 1'b0;
    #1;
    chk("rst_state", 32'(state), 32'(T_IF));
    chk("rst_cycle_count", cycle_count, 0);
    chk("rst_instr_count", instr_count, 0);
    chk("rst_is_halted", 32'(is_halted), 0);
    chk("rst_bus_error", 32'(bus_error), 0);
    chk("rst_iord", 32'(iord), 0);
    chk("rst_mem_write", 32'(mem_write), 0);
    chk("rst_reg_write", 32'(reg_write), 0);
    #1;
    reset = 1'b0;
    prev_st = T_IF; ecyc = 0; eins = 0; ebus = 1'b0;
  endtask

  task automatic add(input logic [6:0] op, input logic mr, input logic [3:0] st);
    vec_t v;
    v.op = op; v.mr = mr; v.st = st;
    tbl.push_back(v);
  endtask

  initial begin
    add(R, 1, T_IF); add(R, 1, T_ID); add(R, 1, T_EXR); add(R, 1, T_AWB);
    add(I, 0, T_IF); add(I, 0, T_IF); add(I, 1, T_IF);
    add(I, 1, T_ID); add(I, 1, T_EXI); add(I, 1, T_AWB);
    add(L, 1, T_IF); add(L, 1, T_ID); add(L, 1, T_MA);
    for (int k = 0; k < 3; k++) add(L, 0, T_MR);
    add(L, 1, T_MR); add(L, 1, T_LWB);
    // mem_ready arriving on the last allowed stall cycle must still complete.
    add(L, 1, T_IF); add(L, 1, T_ID); add(L, 1, T_MA);
    for (int k = 0; k < 4; k++) add(L, 0, T_MR);
    add(L, 1, T_MR); add(L, 1, T_LWB);
    add(S, 1, T_IF); add(S, 1, T_ID); add(S, 1, T_MA); add(S, 1, T_MW);
    add(B, 1, T_IF); add(B, 1, T_ID); add(B, 1, T_BR);
    add(J, 1, T_IF); add(J, 1, T_ID); add(J, 1, T_JAL);
    add(JR, 1, T_IF); add(JR, 1, T_ID); add(JR, 1, T_JALR);
    add(NOP, 1, T_IF); add(NOP, 1, T_ID);
    add(R, 0, T_IF);

    @(negedge clk);
    do_reset();
    for (int i = 0; i < tbl.size(); i++) cyc(tbl[i].op, tbl[i].mr, tbl[i].st);

    // Asynchronous reset while a load is stalled in MR.
    cyc(L, 1, T_IF); cyc(L, 1, T_ID); cyc(L, 1, T_MA); cyc(L, 0, T_MR); cyc(L, 0, T_MR);
    do_reset();

    // ECALL halts and stays halted regardless of mem_ready.
    cyc(E, 1, T_IF); cyc(E, 1, T_ID); cyc(E, 1, T_HALT);
    for (int k = 0; k < 100; k++) cyc(E, 1'($urandom_range(0, 1)), T_HALT);
    do_reset();

    // Store that never completes times out into HALT.
    cyc(S, 1, T_IF); cyc(S, 1, T_ID); cyc(S, 1, T_MA);
    for (int k = 0; k < 5; k++) cyc(S, 0, T_MW);
    ebus = 1'b1;
    for (int k = 0; k < 10; k++) cyc(S, 0, T_HALT);

    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
